// File: rtl/psum_acc_wb.sv
// Partial-sum accumulator with write-back FIFO.
// Accumulates psum column beats across input-channel passes and streams the final pass out.
module psum_acc_wb #(
    parameter int LANES         = 8,
    parameter int PSUM_W        = 16,
    parameter int ACC_W         = 24,
    parameter int TILE_LEN      = 16,
    parameter int CHN_WIDTH     = 4,
    parameter int CHN_OFT_WIDTH = 6,
    parameter int PV_LAT        = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [CHN_WIDTH-1:0]     chi,
    input  logic                     pvalid,
    input  logic [LANES*PSUM_W-1:0]  psum_in,
    input  logic [LANES-1:0]         row_mask,
    input  logic                     ic_done,
    input  logic                     oc_done,
    input  logic                     conv_done,
    output logic                     ofm_valid,
    input  logic                     ofm_ready,
    output logic [LANES*ACC_W-1:0]   ofm_data,
    output logic                     ofm_last,
    output logic                     ofm_conv_last,
    output logic                     busy,
    output logic                     wb_done,
    output logic                     ovf_err,
    output logic                     sync_err
);

    localparam int COL_W  = $clog2(TILE_LEN);
    localparam int CNT_W  = CHN_WIDTH + CHN_OFT_WIDTH;
    localparam int FCNT_W = COL_W + 1;
    localparam int ENT_W  = LANES * ACC_W + 2;

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e                 st_q, st_d;
    logic                   pend_q, pend_d;
    logic                   wb_done_q, wb_done_d;
    logic [PV_LAT-1:0]      ic_sr_q, ic_sr_d, oc_sr_q, oc_sr_d, cv_sr_q, cv_sr_d;
    logic [COL_W-1:0]       col_q, col_d;
    logic [CNT_W-1:0]       ic_cnt_q, ic_cnt_d;
    logic [COL_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FCNT_W-1:0]      cnt_q, cnt_d;
    logic                   ovf_err_q, ovf_err_d;
    logic                   sync_err_q, sync_err_d;

    logic [LANES*ACC_W-1:0] acc_q [TILE_LEN];
    logic [ENT_W-1:0]       mem_q [TILE_LEN];

    logic                   ic_d, oc_d, conv_d;
    logic [CNT_W-1:0]       ic_max;
    logic                   pass_first, pass_last;
    logic [LANES*ACC_W-1:0] acc_rd, beat_sum, beat_out;
    logic [ACC_W-1:0]       lane_ext;
    logic                   acc_we, push_req, push_ok, pop;
    logic [ENT_W-1:0]       rd_ent;

    assign ic_d       = ic_sr_q[PV_LAT-1];
    assign oc_d       = oc_sr_q[PV_LAT-1];
    assign conv_d     = cv_sr_q[PV_LAT-1];
    assign ic_max     = (CNT_W'(chi) << CHN_OFT_WIDTH) - CNT_W'(1);
    assign pass_first = (ic_cnt_q == '0);
    assign pass_last  = (ic_cnt_q == ic_max);
    assign acc_rd     = acc_q[col_q];

    // Per-lane masked, sign-extended sum of the incoming beat with the stored partial.
    always_comb begin
        beat_sum = '0;
        beat_out = '0;
        lane_ext = '0;
        for (int k = 0; k < LANES; k++) begin
            lane_ext = row_mask[k] ? ACC_W'($signed(psum_in[k*PSUM_W +: PSUM_W])) : '0;
            beat_sum[k*ACC_W +: ACC_W] = (pass_first ? '0 : acc_rd[k*ACC_W +: ACC_W]) + lane_ext;
            beat_out[k*ACC_W +: ACC_W] = row_mask[k] ? beat_sum[k*ACC_W +: ACC_W] : '0;
        end
    end

    // Pass bookkeeping, delay lines, FIFO pointers and sticky error flags.
    always_comb begin
        ic_sr_d    = (ic_sr_q << 1) | PV_LAT'(ic_done);
        oc_sr_d    = (oc_sr_q << 1) | PV_LAT'(oc_done);
        cv_sr_d    = (cv_sr_q << 1) | PV_LAT'(conv_done);
        col_d      = col_q;
        ic_cnt_d   = ic_cnt_q;
        acc_we     = pvalid && !pass_last;
        push_req   = pvalid && pass_last;
        pop        = ofm_valid && ofm_ready;
        // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
        push_ok    = push_req && ((cnt_q != FCNT_W'(TILE_LEN)) || pop);
        wr_ptr_d   = wr_ptr_q + COL_W'(push_ok);
        rd_ptr_d   = rd_ptr_q + COL_W'(pop);
        cnt_d      = cnt_q + FCNT_W'(push_ok) - FCNT_W'(pop);
        ovf_err_d  = ovf_err_q | (push_req && !push_ok);
        sync_err_d = sync_err_q | (oc_d && !pass_last) | (ic_d && pass_last && !oc_d);
        if (ic_d) begin
            col_d    = '0;
            ic_cnt_d = pass_last ? '0 : ic_cnt_q + CNT_W'(1);
        end else if (pvalid) begin
            col_d    = col_q + COL_W'(1);
        end
    end

    // Controller: a new convolution seen during drain resumes RUN once the FIFO empties.
    always_comb begin
        st_d      = st_q;
        pend_d    = pend_q;
        wb_done_d = 1'b0;
        unique case (st_q)
            StIdle:  if (pvalid || ic_done) st_d = StRun;
            StRun:   if (conv_d) st_d = StDrain;
            StDrain: begin
                if (pvalid || ic_done) pend_d = 1'b1;
                if (cnt_d == '0) begin
                    st_d      = (pend_q || pvalid || ic_done) ? StRun : StIdle;
                    pend_d    = 1'b0;
                    wb_done_d = 1'b1;
                end
            end
            default: st_d = StIdle;
        endcase
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            st_q       <= StIdle;
            pend_q     <= 1'b0;
            wb_done_q  <= 1'b0;
            ic_sr_q    <= '0;
            oc_sr_q    <= '0;
            cv_sr_q    <= '0;
            col_q      <= '0;
            ic_cnt_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            ovf_err_q  <= 1'b0;
            sync_err_q <= 1'b0;
        end else begin
            st_q       <= st_d;
            pend_q     <= pend_d;
            wb_done_q  <= wb_done_d;
            ic_sr_q    <= ic_sr_d;
            oc_sr_q    <= oc_sr_d;
            cv_sr_q    <= cv_sr_d;
            col_q      <= col_d;
            ic_cnt_q   <= ic_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            ovf_err_q  <= ovf_err_d;
            sync_err_q <= sync_err_d;
        end
    end

    // Accumulator and FIFO storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (acc_we) acc_q[col_q] <= beat_sum;
        if (push_ok) mem_q[wr_ptr_q] <= {ic_d && conv_d, ic_d, beat_out};
    end

    assign rd_ent        = mem_q[rd_ptr_q];
    assign ofm_valid     = (cnt_q != '0);
    assign ofm_data      = rd_ent[LANES*ACC_W-1:0];
    assign ofm_last      = ofm_valid && rd_ent[LANES*ACC_W];
    assign ofm_conv_last = ofm_valid && rd_ent[LANES*ACC_W+1];
    assign busy          = (st_q != StIdle);
    assign wb_done       = wb_done_q;
    assign ovf_err       = ovf_err_q;
    assign sync_err      = sync_err_q;

endmodule

// File: tb/tb_psum_acc_wb.sv
// Scoreboard bench for psum_acc_wb: planned tiles push expected beats, a monitor pops them.
module tb_psum_acc_wb;

    localparam int LANES    = 8;
    localparam int PSUM_W   = 16;
    localparam int ACC_W    = 24;
    localparam int TILE_LEN = 16;
    localparam int PV_LAT   = 3;
    localparam int PASSES   = 64; // chi=1 with 6 offset bits

    logic                    clk = 1'b0;
    logic                    rst;
    logic [3:0]              chi;
    logic                    pvalid, ic_done, oc_done, conv_done, ofm_ready;
    logic [LANES*PSUM_W-1:0] psum_in;
    logic [LANES-1:0]        row_mask;
    logic                    ofm_valid, ofm_last, ofm_conv_last, busy, wb_done, ovf_err, sync_err;
    logic [LANES*ACC_W-1:0]  ofm_data;

    always #5 clk = ~clk;

    psum_acc_wb dut (
        .clk(clk), .rst(rst), .chi(chi), .pvalid(pvalid), .psum_in(psum_in),
        .row_mask(row_mask), .ic_done(ic_done), .oc_done(oc_done), .conv_done(conv_done),
        .ofm_valid(ofm_valid), .ofm_ready(ofm_ready), .ofm_data(ofm_data),
        .ofm_last(ofm_last), .ofm_conv_last(ofm_conv_last), .busy(busy),
        .wb_done(wb_done), .ovf_err(ovf_err), .sync_err(sync_err)
    );

    typedef struct {
        logic                    pv;
        logic [LANES*PSUM_W-1:0] ps;
        logic [LANES-1:0]        mk;
        logic                    ic, oc, cv;
    } cyc_t;

    typedef struct {
        logic [LANES*ACC_W-1:0] data;
        logic                   last;
        logic                   cl;
    } exp_t;

    cyc_t sched[$];
    exp_t exp_q[$];
    int   n_cmp = 0, n_bad = 0;
    int   cyc_no = 0, last_pop_cyc = -100, wb_cnt = 0, wb_lag = -1;
    int   rdy_mode = 2;

    // Monitor state
    logic                   m_stall = 1'b0, m_pwb = 1'b0;
    logic [LANES*ACC_W-1:0] m_pdata;
    logic                   m_plast, m_pcl;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", nm, act, req);
        end
    endtask

    function automatic cyc_t idle_cyc();
        cyc_t c;
        c.pv = 1'b0; c.ps = '0; c.mk = '0; c.ic = 1'b0; c.oc = 1'b0; c.cv = 1'b0;
        return c;
    endfunction

    // Ready driver
    initial begin
        ofm_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       ofm_ready = 1'b0;
                1:       ofm_ready = ($urandom_range(0, 3) != 0);
                default: ofm_ready = 1'b1;
            endcase
        end
    end

    // Monitor: pops the scoreboard on each handshake and checks stall stability.
    initial begin
        forever begin
            exp_t e;
            @(negedge clk);
            cyc_no++;
            if (rst) begin
                m_stall = 1'b0;
                m_pwb   = 1'b0;
            end else begin
                if (m_stall) begin
                    n_cmp++;
                    if (!ofm_valid || ofm_data !== m_pdata || ofm_last !== m_plast ||
                        ofm_conv_last !== m_pcl) begin
                        n_bad++;
                        $display("FAIL hold: valid=%0b data=%h last=%0b cl=%0b required data=%h last=%0b cl=%0b",
                                 ofm_valid, ofm_data, ofm_last, ofm_conv_last, m_pdata, m_plast, m_pcl);
                    end
                end
                if (ofm_valid && ofm_ready) begin
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_bad++;
                        $display("FAIL unexpected beat: data=%h last=%0b required none",
                                 ofm_data, ofm_last);
                    end else begin
                        e = exp_q.pop_front();
                        if (ofm_data !== e.data || ofm_last !== e.last || ofm_conv_last !== e.cl) begin
                            n_bad++;
                            $display("FAIL beat: data=%h last=%0b cl=%0b required data=%h last=%0b cl=%0b",
                                     ofm_data, ofm_last, ofm_conv_last, e.data, e.last, e.cl);
                        end
                    end
                    last_pop_cyc = cyc_no;
                end
                if (wb_done) begin
                    wb_cnt++;
                    wb_lag = cyc_no - last_pop_cyc;
                    chk("wb_done width", {31'd0, m_pwb}, 32'd0);
                end
                m_stall = ofm_valid && !ofm_ready;
                m_pdata = ofm_data;
                m_plast = ofm_last;
                m_pcl   = ofm_conv_last;
                m_pwb   = wb_done;
            end
        end
    end

    // Builds one output-channel tile (PASSES passes of ncols beats) and its expected output.
    task automatic plan(input int ncols, input bit gaps, input bit conv_last, input bit rnd,
                        input logic [15:0] fixed, input logic [7:0] last_mask, input bit push_exp);
        int   sum [TILE_LEN][LANES];
        int   lastidx[$];
        cyc_t c;
        exp_t e;
        logic [15:0] v;
        for (int i = 0; i < TILE_LEN; i++)
            for (int k = 0; k < LANES; k++) sum[i][k] = 0;
        sched.delete();
        for (int i = 0; i < PV_LAT; i++) sched.push_back(idle_cyc());
        for (int p = 0; p < PASSES; p++) begin
            for (int col = 0; col < ncols; col++) begin
                if (gaps) sched.push_back(idle_cyc());
                c = idle_cyc();
                c.pv = 1'b1;
                if (p == PASSES - 1) c.mk = last_mask;
                else if (rnd && $urandom_range(0, 3) == 0) c.mk = 8'($urandom);
                else c.mk = 8'hFF;
                for (int k = 0; k < LANES; k++) begin
                    v = rnd ? 16'($urandom) : fixed;
                    c.ps[k*PSUM_W +: PSUM_W] = v;
                    if (c.mk[k]) sum[col][k] += $signed(v);
                end
                sched.push_back(c);
            end
            lastidx.push_back(sched.size() - 1);
        end
        for (int i = 0; i < PV_LAT; i++) sched.push_back(idle_cyc());
        for (int j = 0; j < lastidx.size(); j++) begin
            sched[lastidx[j] - PV_LAT].ic = 1'b1;
            if (j == lastidx.size() - 1) begin
                sched[lastidx[j] - PV_LAT].oc = 1'b1;
                sched[lastidx[j] - PV_LAT].cv = conv_last;
            end
        end
        if (push_exp) begin
            for (int col = 0; col < ncols; col++) begin
                for (int k = 0; k < LANES; k++)
                    e.data[k*ACC_W +: ACC_W] = last_mask[k] ? ACC_W'(sum[col][k]) : '0;
                e.last = (col == ncols - 1);
                e.cl   = e.last && conv_last;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic drive(input int cut);
        int n;
        n = (cut < 0) ? sched.size() : cut;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            pvalid    = sched[i].pv;
            psum_in   = sched[i].ps;
            row_mask  = sched[i].mk;
            ic_done   = sched[i].ic;
            oc_done   = sched[i].oc;
            conv_done = sched[i].cv;
        end
        @(posedge clk); #1;
        pvalid = 1'b0; psum_in = '0; row_mask = '0;
        ic_done = 1'b0; oc_done = 1'b0; conv_done = 1'b0;
    endtask

    task automatic wait_drain(input string nm);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || busy) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 5000) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s drain timeout: pending=%0d busy=%0b required 0/0", nm, exp_q.size(), busy);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        pvalid = 1'b0; ic_done = 1'b0; oc_done = 1'b0; conv_done = 1'b0;
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        int wb0, nt;
        rst = 1'b1; chi = 4'd1; pvalid = 1'b0; psum_in = '0; row_mask = '0;
        ic_done = 1'b0; oc_done = 1'b0; conv_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset ofm_valid", {31'd0, ofm_valid}, 32'd0);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset wb_done", {31'd0, wb_done}, 32'd0);
        chk("reset ovf_err", {31'd0, ovf_err}, 32'd0);
        chk("reset sync_err", {31'd0, sync_err}, 32'd0);
        chk("reset ofm_last", {30'd0, ofm_last, ofm_conv_last}, 32'd0);
        rst = 1'b0;

        // All lanes 5, full 16-column tile, end of convolution.
        rdy_mode = 2;
        plan(16, 1'b0, 1'b1, 1'b0, 16'd5, 8'hFF, 1'b1);
        drive(-1);
        wait_drain("const5");

        // -1 and 0x7FFF accumulated without saturation.
        plan(4, 1'b0, 1'b0, 1'b0, 16'hFFFF, 8'hFF, 1'b1);
        drive(-1);
        chk("busy mid conv", {31'd0, busy}, 32'd1);
        plan(4, 1'b0, 1'b1, 1'b0, 16'h7FFF, 8'hFF, 1'b1);
        drive(-1);
        wait_drain("wrap");

        // Lane mask on the last pass.
        plan(6, 1'b0, 1'b1, 1'b1, 16'd0, 8'h0F, 1'b1);
        drive(-1);
        wait_drain("mask");

        // Gapped 8-column last tile; wb_done one cycle after the final pop.
        wb0 = wb_cnt;
        plan(8, 1'b1, 1'b1, 1'b1, 16'd0, 8'hFF, 1'b1);
        drive(-1);
        wait_drain("gapped");
        chk("wb_done count", wb_cnt, wb0 + 1);
        chk("wb_done lag", wb_lag, 1);
        chk("idle after drain", {31'd0, busy}, 32'd0);

        // Random tiles with random backpressure.
        rdy_mode = 1;
        nt = 4;
        for (int t = 0; t < nt; t++) begin
            plan($urandom_range(1, 16), 1'($urandom_range(0, 1)),
                 (t == nt - 1) ? 1'b1 : 1'($urandom_range(0, 1)), 1'b1, 16'd0,
                 8'($urandom), 1'b1);
            drive(-1);
        end
        wait_drain("random");
        chk("ovf_err clean", {31'd0, ovf_err}, 32'd0);
        chk("sync_err clean", {31'd0, sync_err}, 32'd0);

        // Full FIFO stalled, then one extra last-pass beat is dropped.
        rdy_mode = 0;
        plan(16, 1'b0, 1'b0, 1'b1, 16'd0, 8'hFF, 1'b1);
        drive(-1);
        chk("no ovf at full", {31'd0, ovf_err}, 32'd0);
        plan(1, 1'b0, 1'b1, 1'b1, 16'd0, 8'hFF, 1'b0);
        drive(-1);
        repeat (4) @(negedge clk);
        chk("ovf_err set", {31'd0, ovf_err}, 32'd1);
        chk("stalled valid", {31'd0, ofm_valid}, 32'd1);
        rdy_mode = 2;
        wait_drain("overflow");
        chk("ovf_err sticky", {31'd0, ovf_err}, 32'd1);

        // Reset in the middle of a last pass discards buffered beats.
        do_reset();
        rst = 1'b0;
        rdy_mode = 0;
        plan(4, 1'b0, 1'b1, 1'b1, 16'd0, 8'hFF, 1'b0);
        drive(sched.size() - 5);
        repeat (2) @(negedge clk);
        chk("beats before reset", {31'd0, ofm_valid}, 32'd1);
        do_reset();
        chk("valid in reset", {31'd0, ofm_valid}, 32'd0);
        chk("ovf_err cleared", {31'd0, ovf_err}, 32'd0);
        rst = 1'b0;
        rdy_mode = 2;
        repeat (10) @(negedge clk);
        chk("valid after reset", {31'd0, ofm_valid}, 32'd0);
        plan(3, 1'b0, 1'b1, 1'b1, 16'd0, 8'hFF, 1'b1);
        drive(-1);
        wait_drain("post reset");

        // oc_done with only three passes done.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1; ic_done = 1'b1;
            @(posedge clk); #1; ic_done = 1'b0;
        end
        repeat (6) @(negedge clk);
        chk("sync_err before oc", {31'd0, sync_err}, 32'd0);
        @(posedge clk); #1; oc_done = 1'b1;
        @(posedge clk); #1; oc_done = 1'b0;
        repeat (5) @(negedge clk);
        chk("sync_err set", {31'd0, sync_err}, 32'd1);
        repeat (20) @(negedge clk);
        chk("sync_err sticky", {31'd0, sync_err}, 32'd1);
        do_reset();
        chk("sync_err reset", {31'd0, sync_err}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/psum_acc_wb.md
PSUM_ACC_WB -- requirements
Module: psum_acc_wb

Interface
REQ-001 Parameters: LANES 8, PE rows per column beat; PSUM_W 16, signed psum lane width; ACC_W 24, signed accumulator lane width; TILE_LEN 16, max column beats per pass; CHN_WIDTH 4; CHN_OFT_WIDTH 6; PV_LAT 3, cycles from ic_done/oc_done/conv_done to the final pvalid of the same pass.
REQ-002 clk  in  1  single clock; all logic on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 chi  in  CHN_WIDTH  input-channel group count; passes per output channel = chi<<CHN_OFT_WIDTH; stable while busy=1.
REQ-005 pvalid  in  1  one psum column beat on psum_in this cycle.
REQ-006 psum_in  in  LANES*PSUM_W  lane k in bits [k*PSUM_W +: PSUM_W], signed.
REQ-007 row_mask  in  LANES  lane enable, sampled with pvalid.
REQ-008 ic_done, oc_done, conv_done  in  1 each  controller pulses, each arriving PV_LAT cycles before the last pvalid of its pass.
REQ-009 ofm_valid  out  1 / ofm_ready  in  1 / ofm_data  out  LANES*ACC_W  result beat handshake.
REQ-010 ofm_last  out  1  beat is the final column of an output channel tile; ofm_conv_last  out  1  final beat of the convolution.
REQ-011 busy  out  1; wb_done  out  1  one-cycle pulse; ovf_err  out  1 sticky; sync_err  out  1 sticky.

Function
REQ-012 Delay line: ic_done, oc_done and conv_done SHALL each be delayed exactly PV_LAT cycles (ic_d, oc_d, conv_d); pass boundaries use only the delayed copies.
REQ-013 Column pointer col (log2 TILE_LEN bits) SHALL increment on each pvalid and reset to 0 in the cycle after ic_d; pvalid gaps (stride 2) SHALL not advance col.
REQ-014 Pass counter ic_cnt (CHN_WIDTH+CHN_OFT_WIDTH bits) SHALL increment on ic_d and clear to 0 when ic_d occurs with ic_cnt == (chi<<CHN_OFT_WIDTH)-1.
REQ-015 first pass (ic_cnt==0): acc[col] <= sign-extended masked psum; later passes: acc[col] <= acc[col] + sign-extended masked psum, modulo 2^ACC_W per lane (wrap, no saturation).
REQ-016 Masked lanes (row_mask[k]=0) SHALL contribute 0 and SHALL output 0.
REQ-017 Last pass (ic_cnt == max): the summed value SHALL be pushed into an output FIFO of depth TILE_LEN instead of acc; the beat coinciding with ic_d carries ofm_last=1, and ofm_conv_last=1 if conv_d is also set.
REQ-018 Last-pass pvalid and ic_d coinciding (single-column pass) SHALL be handled in one cycle without loss.
REQ-019 sync_err SHALL set if oc_d arrives while ic_cnt != max, or if ic_d arrives while ic_cnt == max and oc_d is absent.
REQ-020 FIFO push while full SHALL drop the beat and set ovf_err; push and pop in the same cycle while full SHALL succeed.
REQ-021 ofm_data/ofm_last/ofm_conv_last SHALL be held stable while ofm_valid=1 and ofm_ready=0; pop on ofm_valid & ofm_ready; first-word latency 1 cycle after push.
REQ-022 FSM IDLE->RUN on first pvalid or ic_done; RUN->DRAIN on conv_d; DRAIN->IDLE when FIFO empty, with wb_done pulsed for one cycle on that transition; busy=1 in RUN and DRAIN.
REQ-023 pvalid in DRAIN SHALL be processed as a new convolution (state returns to RUN after DRAIN completes; beats are not dropped).

Reset
REQ-024 While rst=1: FSM=IDLE, col=0, ic_cnt=0, delay lines cleared, FIFO emptied, ofm_valid=0, ofm_last=0, ofm_conv_last=0, busy=0, wb_done=0, ovf_err=0, sync_err=0; acc contents undefined, overwritten by next first pass.
REQ-025 rst asserted mid-pass SHALL discard all in-flight beats; no output beat SHALL appear until a new last pass completes.

Verification
REQ-026 chi=1 override to 2 passes (test param CHN_OFT_WIDTH=0, chi=2), 16 beats/pass, all lanes psum=5 -> 16 beats, each lane 10, ofm_last on beat 16.
REQ-027 Lane psum=-1 over 64 passes (chi=1) -> lane value 24'hFFFFC0; psum=16'h7FFF x64 -> 24'h1FFFC0 (no saturation).
REQ-028 row_mask=8'h0F on last pass -> lanes 4..7 read 0, lanes 0..3 correct.
REQ-029 ofm_ready=0 through a full tile plus one extra last-pass beat -> 16 beats held stable, extra beat dropped, ovf_err=1.
REQ-030 Stride-2 style gapped pvalid, 8-column last tile with conv_done -> 8 beats, final ofm_last=ofm_conv_last=1, wb_done pulse 1 cycle after final pop.
REQ-031 oc_done injected while ic_cnt=3 -> sync_err=1, stays set until rst.
